// File: rtl/afm_uart_pkg.sv
// Shared AFM UART definitions (used by both RX and TX blocks).
package afm_uart_pkg;

    // Receive frame FSM states
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int         CLKS_PER_BIT_DEFAULT = 234;     // 27 MHz / 115200
    localparam logic [7:0] LINE_TERM_DEFAULT    = 8'h0A;   // '\n'

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO. The head entry is presented on rd_data
// whenever the FIFO is non-empty; rd_data reads 0 while empty.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_acc, wr_acc;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem[rd_ptr_q];

    // A pop frees the head slot this cycle, so a write into a full FIFO
    // alongside a pop is accepted.
    assign pop_acc = rd_en && !empty;
    assign wr_acc  = wr_en && (!full || pop_acc);

    // Storage array; no reset needed since empty gates the read port
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= wr_data;
    end

    // Pointers wrap naturally; occupancy tracks write/pop balance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_acc)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_acc, pop_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_line_rx.sv
// UART line receiver: 2-flop synchroniser, mid-bit sampling frame FSM and
// FWFT byte FIFO with line-terminator / error / overflow flags.
// Optional even parity (8E1) when UART_RX_PARITY_EN is defined; otherwise 8N1
// and parity_err is tied low.
module uart_line_rx
    import afm_uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int         FIFO_DEPTH   = 16,
    parameter logic [7:0] LINE_TERM    = LINE_TERM_DEFAULT
) (
    input  logic                          clk,
    input  logic                          btn1,
    input  logic                          uart_rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          line_done,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    logic            rx_s1, rx_s2;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_bad_q, par_bad_d;
    logic            wr_en, fe_set, pe_set;
    logic            fifo_full, fifo_empty, pop;
    logic            line_done_q, frame_err_q, overflow_q;

    // Two-flop synchroniser, idles high so reset does not look like a start bit
    always_ff @(posedge clk or negedge btn1) begin
        if (!btn1) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
        end
    end

    // Frame FSM state and datapath registers
    always_ff @(posedge clk or negedge btn1) begin
        if (!btn1) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
        end
    end

    // Next-state: half-bit to centre on the start bit, then full bit periods
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        wr_en     = 1'b0;
        fe_set    = 1'b0;
        pe_set    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                idx_d     = '0;
                par_bad_d = 1'b0;
                if (!rx_s2) state_d = START;
            end
            START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // a high sample here means the low was a glitch
                    state_d = rx_s2 ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s2;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d     = '0;
                    par_bad_d = (rx_s2 != ^shift_q);
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    // framing error wins over parity; either discards the byte
                    if (!rx_s2)         fe_set = 1'b1;
                    else if (par_bad_q) pe_set = 1'b1;
                    else                wr_en  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop = rx_valid && rx_ready;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (btn1),
        .wr_en   (wr_en),
        .wr_data (shift_q),
        .rd_en   (rx_ready),
        .rd_data (rx_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rx_valid = !fifo_empty;

    // Status pulses one cycle after the stop sample; overflow is sticky
    always_ff @(posedge clk or negedge btn1) begin
        if (!btn1) begin
            line_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            line_done_q <= wr_en && (!fifo_full || pop) && (shift_q == LINE_TERM);
            frame_err_q <= fe_set;
            overflow_q  <= overflow_q || (wr_en && fifo_full && !pop);
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;

    // Parity mismatch pulse, aligned with the other status pulses
    always_ff @(posedge clk or negedge btn1) begin
        if (!btn1) parity_err_q <= 1'b0;
        else       parity_err_q <= pe_set;
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign line_done = line_done_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_line_rx.sv
// Directed bench for uart_line_rx (CLKS_PER_BIT=16, FIFO_DEPTH=4).
module tb_uart_line_rx;
    localparam int CLKS  = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       btn1;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       line_done, frame_err, parity_err, overflow;
    logic [2:0] fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rxq[$];
    int         n_ld = 0, n_fe = 0, n_pe = 0;
    logic [7:0] ld_byte = 8'h00;

    uart_line_rx #(
        .CLKS_PER_BIT (CLKS),
        .FIFO_DEPTH   (DEPTH),
        .LINE_TERM    (8'h0A)
    ) dut (
        .clk        (clk),
        .btn1       (btn1),
        .uart_rx    (uart_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .line_done  (line_done),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // Record pops and pulse counts away from the active edge
    always @(negedge clk) begin
        if (btn1) begin
            if (rx_valid && rx_ready) rxq.push_back(rx_data);
            if (line_done) begin
                n_ld++;
                ld_byte = rx_data;
            end
            if (frame_err)  n_fe++;
            if (parity_err) n_pe++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] qat(input int i);
        return (i < rxq.size()) ? {24'h0, rxq[i]} : 32'hDEAD;
    endfunction

    task automatic drv(input logic v);
        uart_rx = v;
        repeat (CLKS) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_v,
                        input logic with_par, input logic par_v);
        drv(1'b0);
        for (int i = 0; i < 8; i++) drv(b[i]);
        if (with_par) drv(par_v);
        drv(stop_v);
        uart_rx = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, ld0, fe0, pe0;
        btn1     = 1'b0;
        uart_rx  = 1'b1;
        rx_ready = 1'b1;
        #2;
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ld", line_done, 0);
        chk("rst_fe", frame_err, 0);
        chk("rst_pe", parity_err, 0);
        repeat (3) @(posedge clk);
        #1;
        btn1 = 1'b1;
        idle(5);

        // "Hi\n" back-to-back, consumer always ready
        base = rxq.size(); ld0 = n_ld; fe0 = n_fe; pe0 = n_pe;
        send(8'h48, 1'b1, 1'b0, 1'b0);
        send(8'h69, 1'b1, 1'b0, 1'b0);
        send(8'h0A, 1'b1, 1'b0, 1'b0);
        idle(20);
        chk("hi_n", rxq.size() - base, 3);
        chk("hi_b0", qat(base), 8'h48);
        chk("hi_b1", qat(base + 1), 8'h69);
        chk("hi_b2", qat(base + 2), 8'h0A);
        chk("hi_ld_n", n_ld - ld0, 1);
        chk("hi_ld_byte", ld_byte, 8'h0A);
        chk("hi_fe", n_fe - fe0, 0);
        chk("hi_pe", n_pe - pe0, 0);

        // Overflow: five bytes into a depth-4 FIFO with no pops
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0, 1'b0);
        idle(20);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_valid", rx_valid, 1);
        chk("ovf_head", rx_data, 8'h01);
        base = rxq.size();
        rx_ready = 1'b1;
        idle(10);
        chk("ovf_n", rxq.size() - base, 4);
        for (int i = 0; i < 4; i++) chk("ovf_pop", qat(base + i), 32'(i + 1));
        chk("ovf_empty", fifo_count, 0);

        // Framing error, then a clean byte
        base = rxq.size(); fe0 = n_fe;
        send(8'h55, 1'b0, 1'b0, 1'b0);
        idle(2 * CLKS);
        chk("fe_n", n_fe - fe0, 1);
        chk("fe_none", rxq.size() - base, 0);
        chk("fe_valid", rx_valid, 0);
        send(8'hAA, 1'b1, 1'b0, 1'b0);
        idle(20);
        chk("fe_aa_n", rxq.size() - base, 1);
        chk("fe_aa", qat(base), 8'hAA);
        chk("fe_once", n_fe - fe0, 1);

        // Short low glitch, shorter than half a bit
        base = rxq.size(); ld0 = n_ld; fe0 = n_fe; pe0 = n_pe;
        uart_rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle(40);
        chk("gl_none", rxq.size() - base, 0);
        chk("gl_flags", (n_ld - ld0) + (n_fe - fe0) + (n_pe - pe0), 0);
        send(8'h5A, 1'b1, 1'b0, 1'b0);
        idle(20);
        chk("gl_rearm", qat(base), 8'h5A);

        // Reset during bit 3 of 0xC3 with a byte and overflow pending
        rx_ready = 1'b0;
        send(8'h11, 1'b1, 1'b0, 1'b0);
        idle(5);
        chk("mr_pre", rx_valid, 1);
        drv(1'b0);
        for (int i = 0; i < 3; i++) drv(i < 2);   // 0xC3 bits 0..2 = 1,1,0
        uart_rx = 1'b0;                           // bit 3 of 0xC3
        repeat (CLKS / 2) @(posedge clk);
        #1;
        btn1 = 1'b0;
        #1;
        chk("mr_valid", rx_valid, 0);
        chk("mr_data", rx_data, 8'h00);
        chk("mr_count", fifo_count, 0);
        chk("mr_ovf", overflow, 0);
        chk("mr_pulses", {line_done, frame_err, parity_err}, 0);
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        btn1 = 1'b1;
        rx_ready = 1'b1;
        idle(5);
        base = rxq.size();
        send(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(20);
        chk("mr_n", rxq.size() - base, 1);
        chk("mr_3c", qat(base), 8'h3C);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the parity bit must be 1
        base = rxq.size(); pe0 = n_pe;
        send(8'h07, 1'b1, 1'b1, 1'b0);
        idle(20);
        chk("pe_n", n_pe - pe0, 1);
        chk("pe_drop", rxq.size() - base, 0);
        send(8'h07, 1'b1, 1'b1, 1'b1);
        idle(20);
        chk("pe_ok", qat(base), 8'h07);
        chk("pe_once", n_pe - pe0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_line_rx.md
# uart_line_rx

Standalone UART receiver for the AFM module: the receive end of the newline-terminated ASCII stream our TX path emits. Synchronises `uart_rx`, decodes 8N1 frames (8E1 optionally) with mid-bit sampling, and queues bytes in a first-word-fall-through FIFO with a ready/valid read port. It also flags line terminators, framing errors and overflow for LED and status logic.

## Interface
Parameters:
- `CLKS_PER_BIT`, 234, clocks per bit (27 MHz / 115200); legal ≥ 4.
- `FIFO_DEPTH`, 16, byte FIFO entries; power of two, ≥ 2.
- `LINE_TERM`, 8'h0A, byte value that raises `line_done`.

Ports:
- `clk`  in  1  system clock.
- `btn1`  in  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `uart_rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `rx_data`  out  8  FIFO head byte; valid only while `rx_valid`=1.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer pop; a pop occurs when `rx_valid && rx_ready` at a rising edge.
- `line_done`  out  1  one-cycle pulse when a byte equal to `LINE_TERM` is written to the FIFO.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples low.
- `parity_err`  out  1  one-cycle pulse on parity mismatch; tied 0 when parity is not compiled in.
- `overflow`  out  1  sticky; set when a good byte arrives to a full FIFO. Cleared only by reset.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- Input: two-flop synchroniser on `uart_rx` resets to 1. The FSM uses the second stage only.
- Bit counter width is $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2, rounded down.
- FSM states:
  - IDLE: counters cleared. A synchronised 0 moves the FSM to START.
  - START: count to HALF-1, then sample. If the sample is 0, go to DATA with bit index 0 and counter cleared. If it is 1 (glitch), return to IDLE with no flags.
  - DATA: each time the counter reaches CLKS_PER_BIT-1, sample into `shift[idx]`, LSB first. After idx 7, go to STOP (or PARITY when enabled).
  - PARITY: sample after CLKS_PER_BIT clocks and compare with the even parity of `shift`.
  - STOP: sample after CLKS_PER_BIT clocks, then return to IDLE on the same edge.
- Stop-bit outcome:
  - Stop = 1 and parity OK: write the byte to the FIFO.
  - Stop = 0: pulse `frame_err` and discard the byte. Do not wait for the line to go high; IDLE re-arms on the next low.
  - Parity bad with stop = 1: pulse `parity_err` and discard the byte.
- FIFO behaviour:
  - Full with a good byte arriving: drop the byte, set `overflow`, no `line_done`.
  - Simultaneous write and pop: both occur, count unchanged. This holds when full, so the write is not dropped.
  - Pop when empty is ignored.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- Reset mid-frame: all state returns to IDLE, FIFO empty, every output at its reset value. A partial frame is discarded.

## Timing
- Reset values: `rx_data`=8'h00, `rx_valid`=0, `line_done`=0, `frame_err`=0, `parity_err`=0, `overflow`=0, `fifo_count`=0.
- Line to sample: 2 cycles of synchroniser latency.
- Stop-bit sample edge to `rx_valid`=1: 1 cycle. On an empty FIFO, `rx_data` is valid in the same cycle.
- `line_done`, `frame_err` and `parity_err` assert in the cycle after the stop sample, for exactly 1 cycle.
- After a pop, the next head appears in `rx_data` on the following cycle; no bubble.
- Back-to-back frames with a single stop bit are received without loss.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frames are 8E1 with a PARITY state between DATA and STOP.
  - `parity_err` is live.
- Undefined:
  - Frames are 8N1 and no PARITY state exists.
  - `parity_err` is constant 0.

## Structure
- Package `afm_uart_pkg` holds:
  - The RX state enum: IDLE, START, DATA, PARITY, STOP.
  - Default constants `CLKS_PER_BIT_DEFAULT` (234) and `LINE_TERM_DEFAULT` (8'h0A).
  - This package is shared with the TX block.
- One sub-module, `uart_rx_fifo`: a synchronous first-word-fall-through FIFO with write, pop, count and full/empty outputs, on the same clock and reset. The frame FSM stays in `uart_line_rx`.

## Test plan
- Bench settings: `CLKS_PER_BIT`=16, `FIFO_DEPTH`=4.
- Send "Hi\n" (48,69,0A) with `rx_ready`=1 → `rx_data` shows 48, 69, 0A in order. `line_done` pulses once, on 0A; no error flags.
- Send 5 bytes 01..05 with `rx_ready`=0 → `fifo_count`=4 and `overflow`=1. Popping returns 01..04; 05 is lost.
- Send 8'h55 with a stop bit of 0 → one `frame_err` pulse, `rx_valid` stays 0. A following 8'hAA is received correctly.
- Pull the line low for 5 clocks (less than HALF) → no byte and no flags; the FSM returns to IDLE.
- Assert `btn1` low during bit 3 of 8'hC3 → outputs at reset values. The next frame, 8'h3C, is received intact.
- With `UART_RX_PARITY_EN`:
  - 8'h07 with parity bit 0 → `parity_err` pulse, nothing queued.
  - 8'h07 with parity bit 1 → accepted.
